mext_mul_ctrl: RTL and testbench

//  Sequencer between the EX stage and the iterative multiplier for RV32M MUL/MULH/MULHSU/MULHU.
//  - Accepts a request from EX, latches operands and holds them stable for the multiplier.
//  - Issues a one-cycle start, waits for fin, then captures the 64-bit product and returns the selected 32-bit word.
//  - Stalls the pipeline while the multiply is in flight.
//  - A one-entry product cache lets the common MULH;MUL pair on identical operands finish with zero stall.

---
 rtl/mext_mul_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mext_mul_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mext_mul_ctrl.sv
// ============================================================================
// Module   : mext_mul_ctrl
// Purpose  : EX-stage sequencer for the iterative RV32M multiplier, with a
//            one-entry product cache so MULH;MUL pairs finish without stall.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mext_mul_ctrl #(
    parameter int REUSE_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mul_req,
    input  logic [2:0]  mul_op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        mul_stall,
    output logic        mul_done,
    output logic [31:0] mul_result,
    output logic        mult_start,
    output logic [2:0]  mult_op,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    input  logic        mult_fin,
    input  logic [63:0] mult_product
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_DRAIN = 3'd4;

    localparam logic [2:0] c_OP_MUL   = 3'b000;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;

    logic [2:0]  r_mult_op;
    logic [31:0] r_mult_a;
    logic [31:0] r_mult_b;

    logic        r_cache_valid;
    logic [2:0]  r_c_op;
    logic [31:0] r_c_a;
    logic [31:0] r_c_b;
    logic [63:0] r_c_prod;

    logic        w_ours;
    logic        w_op_match;
    logic        w_hit;
    logic        w_latch;
    logic        w_capture;

    function automatic logic [31:0] f_sel(input logic [2:0] op, input logic [63:0] prod);
        f_sel = (op == c_OP_MUL) ? prod[31:0] : prod[63:32];
    endfunction

    // Low word never depends on signedness; MUL and MULH share signed-signed products.
    assign w_ours     = mul_req & ~mul_op[2];
    assign w_op_match = (mul_op == c_OP_MUL) || (mul_op == r_c_op) ||
                        ((mul_op[2:1] == 2'b00) && (r_c_op[2:1] == 2'b00));
    assign w_hit      = (REUSE_EN != 0) && r_cache_valid && (rs1 == r_c_a) &&
                        (rs2 == r_c_b) && w_op_match;

    assign w_latch    = (r_state == c_ST_IDLE) && w_ours && !flush && !w_hit;
    assign w_capture  = (r_state == c_ST_WAIT) && mult_fin && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_ours && !flush && !w_hit) begin
                    w_next_state = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                w_next_state = flush ? c_ST_DRAIN : c_ST_WAIT;
            end
            c_ST_WAIT: begin
                // A flush coinciding with fin has nothing left to drain.
                if (flush) begin
                    w_next_state = mult_fin ? c_ST_IDLE : c_ST_DRAIN;
                end else if (mult_fin) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_next_state = c_ST_IDLE;
            end
            c_ST_DRAIN: begin
                if (mult_fin) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mult_op     <= 3'd0;
            r_mult_a      <= 32'd0;
            r_mult_b      <= 32'd0;
            r_cache_valid <= 1'b0;
            r_c_op        <= 3'd0;
            r_c_a         <= 32'd0;
            r_c_b         <= 32'd0;
            r_c_prod      <= 64'd0;
        end else begin
            if (w_latch) begin
                r_mult_op <= mul_op;
                r_mult_a  <= rs1;
                r_mult_b  <= rs2;
            end
            if (w_capture) begin
                r_cache_valid <= 1'b1;
                r_c_op        <= r_mult_op;
                r_c_a         <= r_mult_a;
                r_c_b         <= r_mult_b;
                r_c_prod      <= mult_product;
            end
        end
    end

    always_comb begin
        mul_stall  = 1'b0;
        mul_done   = 1'b0;
        mul_result = 32'd0;
        mult_start = 1'b0;
        if (!rst) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_ours && !flush) begin
                        if (w_hit) begin
                            mul_done   = 1'b1;
                            mul_result = f_sel(mul_op, r_c_prod);
                        end else begin
                            mul_stall  = 1'b1;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    mult_start = 1'b1;
                    mul_stall  = 1'b1;
                end
                c_ST_WAIT: begin
                    mul_stall  = 1'b1;
                end
                c_ST_DONE: begin
                    if (!flush) begin
                        mul_done   = 1'b1;
                        mul_result = f_sel(r_mult_op, r_c_prod);
                    end
                end
                c_ST_DRAIN: begin
                    mul_stall  = mul_req;
                end
                default: begin
                    mul_stall  = 1'b0;
                end
            endcase
        end
    end

    assign mult_op = r_mult_op;
    assign mult_a  = r_mult_a;
    assign mult_b  = r_mult_b;

endmodule

`default_nettype wire

// File: tb/tb_mext_mul_ctrl.sv
// ============================================================================
// Module   : tb_mext_mul_ctrl
// Purpose  : Scoreboard bench for mext_mul_ctrl with a 34-cycle multiplier model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mext_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_req;
    logic [2:0]  mul_op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        mul_stall;
    logic        mul_done;
    logic [31:0] mul_result;
    logic        mult_start;
    logic [2:0]  mult_op;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic        mult_fin;
    logic [63:0] mult_product;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mext_mul_ctrl #(.REUSE_EN(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .mul_req      (mul_req),
        .mul_op       (mul_op),
        .rs1          (rs1),
        .rs2          (rs2),
        .flush        (flush),
        .mul_stall    (mul_stall),
        .mul_done     (mul_done),
        .mul_result   (mul_result),
        .mult_start   (mult_start),
        .mult_op      (mult_op),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_fin     (mult_fin),
        .mult_product (mult_product)
    );

    // Multiplier model: fin 34 cycles after the start cycle, product only valid with fin.
    function automatic logic [63:0] f_prod(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = (op == 3'b011) ? {32'd0, a} : {{32{a[31]}}, a};
        eb = (op == 3'b010 || op == 3'b011) ? {32'd0, b} : {{32{b[31]}}, b};
        f_prod = ea * eb;
    endfunction

    logic [5:0]  m_cnt;
    logic [63:0] m_prod;
    logic        m_fin;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 6'd0;
            m_fin <= 1'b0;
        end else begin
            m_fin <= 1'b0;
            if (mult_start) begin
                m_cnt  <= 6'd33;
                m_prod <= f_prod(mult_op, mult_a, mult_b);
            end else if (m_cnt != 6'd0) begin
                m_cnt <= m_cnt - 6'd1;
                if (m_cnt == 6'd1) m_fin <= 1'b1;
            end
        end
    end

    assign mult_fin     = m_fin;
    assign mult_product = m_fin ? m_prod : 64'hA5A5_5A5A_C3C3_3C3C;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports a result.
    always @(negedge clk) begin
        logic [31:0] e;
        if (mult_start) start_cnt++;
        if (mul_done) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got result %0h, none expected", mul_result);
            end else begin
                e = exp_q.pop_front();
                if (mul_result !== e) begin
                    fails++;
                    $display("FAIL result: got %0h expected %0h", mul_result, e);
                end
            end
        end else begin
            tests++;
            if (mul_result !== 32'd0) begin
                fails++;
                $display("FAIL result_zero_when_idle: got %0h expected 0", mul_result);
            end
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit hit);
        int  s0;
        int  n;
        bit  seen;
        bit  stall_ok;
        logic fin_last;
        @(posedge clk); #1;
        mul_req = 1'b1; mul_op = op; rs1 = a; rs2 = b;
        exp_q.push_back(exp);
        s0 = start_cnt;
        if (hit) begin
            @(negedge clk);
            chk("hit_stall", {63'd0, mul_stall}, 64'd0);
            chk("hit_done", {63'd0, mul_done}, 64'd1);
        end else begin
            n = 0; seen = 1'b0; stall_ok = 1'b1; fin_last = 1'b0;
            while (!seen && n < 200) begin
                @(negedge clk);
                n++;
                if (mul_done) begin
                    seen = 1'b1;
                    chk("done_stall_low", {63'd0, mul_stall}, 64'd0);
                    chk("done_after_fin", {63'd0, fin_last}, 64'd1);
                end else if (!mul_stall) begin
                    stall_ok = 1'b0;
                end
                fin_last = mult_fin;
            end
            chk("miss_done_seen", {63'd0, seen}, 64'd1);
            chk("miss_stall_held", {63'd0, stall_ok}, 64'd1);
        end
        @(posedge clk); #1;
        mul_req = 1'b0;
        chk(hit ? "hit_no_start" : "miss_one_start", 64'(start_cnt - s0), hit ? 64'd0 : 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        int  s0;
        bit  seen;
        bit  ok;
        bit  aok;
        logic fin_last;

        rst = 1'b1; mul_req = 1'b0; mul_op = 3'd0; rs1 = 32'd0; rs2 = 32'd0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", {63'd0, mul_stall}, 64'd0);
        chk("reset_done", {63'd0, mul_done}, 64'd0);
        chk("reset_start", {63'd0, mult_start}, 64'd0);
        chk("reset_mult_a", {32'd0, mult_a}, 64'd0);

        // Not an M-multiply: ignored entirely.
        @(posedge clk); #1;
        mul_req = 1'b1; mul_op = 3'b100; rs1 = 32'd1; rs2 = 32'd2;
        s0 = start_cnt;
        repeat (3) begin
            @(negedge clk);
            chk("foreign_op_stall", {63'd0, mul_stall}, 64'd0);
        end
        @(posedge clk); #1 mul_req = 1'b0;
        chk("foreign_op_no_start", 64'(start_cnt - s0), 64'd0);

        do_op(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        do_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        do_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 32'hF8CC_93D6, 1'b0);
        do_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 1'b0);

        // Flush mid-WAIT, then a request that hits the untouched cache once drained.
        @(posedge clk); #1;
        mul_req = 1'b1; mul_op = 3'b000; rs1 = 32'd3; rs2 = 32'd5;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mult_start && n < 20);
        chk("flush_start_seen", {63'd0, mult_start}, 64'd1);
        repeat (5) @(posedge clk);
        #1 flush = 1'b1; mul_req = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0; mul_req = 1'b1; mul_op = 3'b011; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0;
        exp_q.push_back(32'h0B00_EA4E);
        s0 = start_cnt;
        n = 0; seen = 1'b0; ok = 1'b1; aok = 1'b1; fin_last = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (mul_done) begin
                seen = 1'b1;
                chk("drain_hit_stall", {63'd0, mul_stall}, 64'd0);
                chk("drain_done_after_fin", {63'd0, fin_last}, 64'd1);
            end else begin
                if (!mul_stall) ok = 1'b0;
                if (mult_a !== 32'd3) aok = 1'b0;
            end
            fin_last = mult_fin;
        end
        chk("drain_done_seen", {63'd0, seen}, 64'd1);
        chk("drain_stall_held", {63'd0, ok}, 64'd1);
        chk("drain_operands_held", {63'd0, aok}, 64'd1);
        @(posedge clk); #1 mul_req = 1'b0;
        chk("drain_cache_hit_no_start", 64'(start_cnt - s0), 64'd0);

        // Reset in WAIT: aborted op produces nothing; cache is cleared.
        @(posedge clk); #1;
        mul_req = 1'b1; mul_op = 3'b000; rs1 = 32'd9; rs2 = 32'd9;
        repeat (12) @(posedge clk);
        #1 rst = 1'b1; mul_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall", {63'd0, mul_stall}, 64'd0);
        chk("rst_mid_done", {63'd0, mul_done}, 64'd0);
        chk("rst_mid_start", {63'd0, mult_start}, 64'd0);
        chk("rst_mid_mult_a", {32'd0, mult_a}, 64'd0);
        chk("rst_mid_mult_op", {61'd0, mult_op}, 64'd0);
        do_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
